// File: rtl/xup_tri_bus_arbiter.sv
// Round-robin arbiter for a shared tri-state bus with registered grants and a forced 'z' turnaround window.
// Optional bus readback contention checker enabled by XUP_TRI_BUS_CONTENTION_CHK_EN.
`timescale 1ns/1ps
module xup_tri_bus_arbiter #(
  parameter int SIZE      = 8,
  parameter int CHANNELS  = 4,
  parameter int DELAY     = 3,
  parameter int TA_CYCLES = 1,
  parameter int MAX_BURST = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CHANNELS*SIZE-1:0]    a,
  input  logic [CHANNELS-1:0]         req,
  output logic [CHANNELS-1:0]         grant,
  output logic [SIZE-1:0]             y,
  output logic                        busy,
  output logic [$clog2(CHANNELS)-1:0] owner_id
`ifdef XUP_TRI_BUS_CONTENTION_CHK_EN
  ,
  input  logic [SIZE-1:0]             bus_in,
  output logic                        contention
`endif
);

  localparam int OW = $clog2(CHANNELS);
  localparam int BW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(TA_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DRIVE      = 2'd1,
    TURNAROUND = 2'd2
  } state_t;

  state_t                state_r, state_n;
  logic [CHANNELS-1:0]   grant_r, grant_n;
  logic [OW-1:0]         owner_r, owner_n;
  logic [BW-1:0]         burst_r, burst_n, burst_inc_s;
  logic [TW-1:0]         ta_r, ta_n;
  logic                  busy_r;
  logic [OW-1:0]         pick_s;
  logic [CHANNELS-1:0]   pick_oh_s, own_oh_s;
  logic                  others_s, limit_hit_s;
  logic [SIZE-1:0]       sel_data_s, y_dly_s;
  logic                  drive_dly_s;

  // Previous owner gets lowest priority: the search starts one past it and ends on it.
  function automatic logic [OW-1:0] rr_pick(input logic [CHANNELS-1:0] r, input logic [OW-1:0] last);
    logic [OW-1:0] pick;
    logic [OW-1:0] idx;
    logic          found;
    logic          hit;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx   = OW'((int'(last) + k) % CHANNELS);
      hit   = !found && r[idx];
      pick  = hit ? idx : pick;
      found = found | hit;
    end
    return pick;
  endfunction

  function automatic logic [CHANNELS-1:0] to_onehot(input logic [OW-1:0] idx);
    return {{(CHANNELS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Selection, burst accounting and owner data mux.
  always_comb begin
    pick_s      = rr_pick(req, owner_r);
    pick_oh_s   = to_onehot(pick_s);
    own_oh_s    = to_onehot(owner_r);
    others_s    = (req & ~own_oh_s) != {CHANNELS{1'b0}};
    if (MAX_BURST == 0) begin
      burst_inc_s = {BW{1'b0}};
    end else if (burst_r == BW'(MAX_BURST)) begin
      burst_inc_s = burst_r;
    end else begin
      burst_inc_s = burst_r + {{(BW-1){1'b0}}, 1'b1};
    end
    limit_hit_s = (MAX_BURST != 0) && (burst_inc_s == BW'(MAX_BURST));
    sel_data_s  = {SIZE{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      sel_data_s = (owner_r == OW'(i)) ? a[i*SIZE +: SIZE] : sel_data_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state_r;
    grant_n = grant_r;
    owner_n = owner_r;
    burst_n = burst_r;
    ta_n    = ta_r;
    case (state_r)
      IDLE: begin
        if (req != {CHANNELS{1'b0}}) begin
          state_n = DRIVE;
          owner_n = pick_s;
          grant_n = pick_oh_s;
          burst_n = {BW{1'b0}};
        end else begin
          grant_n = {CHANNELS{1'b0}};
        end
      end
      DRIVE: begin
        if (!req[owner_r] || (limit_hit_s && others_s)) begin
          state_n = TURNAROUND;
          grant_n = {CHANNELS{1'b0}};
          ta_n    = {TW{1'b0}};
        end else begin
          grant_n = own_oh_s;
          burst_n = burst_inc_s;
        end
      end
      TURNAROUND: begin
        if (ta_r == TW'(TA_CYCLES - 1)) begin
          if (req != {CHANNELS{1'b0}}) begin
            state_n = DRIVE;
            owner_n = pick_s;
            grant_n = pick_oh_s;
            burst_n = {BW{1'b0}};
          end else begin
            state_n = IDLE;
            grant_n = {CHANNELS{1'b0}};
          end
        end else begin
          ta_n    = ta_r + {{(TW-1){1'b0}}, 1'b1};
          grant_n = {CHANNELS{1'b0}};
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = {CHANNELS{1'b0}};
      end
    endcase
  end

  // State and registered outputs; reset drops the bus with no turnaround.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      grant_r <= {CHANNELS{1'b0}};
      owner_r <= OW'(CHANNELS - 1);
      burst_r <= {BW{1'b0}};
      ta_r    <= {TW{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      grant_r <= grant_n;
      owner_r <= owner_n;
      burst_r <= burst_n;
      ta_r    <= ta_n;
      busy_r  <= (state_n != IDLE);
    end
  end

  assign #(DELAY) y_dly_s     = sel_data_s;
  assign #(DELAY) drive_dly_s = |grant_r;
  assign y        = drive_dly_s ? y_dly_s : {SIZE{1'bz}};
  assign grant    = grant_r;
  assign busy     = busy_r;
  assign owner_id = owner_r;

`ifdef XUP_TRI_BUS_CONTENTION_CHK_EN
  logic cont_flag_s, cont_prev_r, contention_r;

  // Mismatch while driving, or any non-'z' value while the bus should float.
  always_comb begin
    if (state_r == DRIVE) begin
      cont_flag_s = (bus_in != sel_data_s);
    end else begin
      cont_flag_s = (bus_in !== {SIZE{1'bz}});
    end
  end

  // Two consecutive bad samples set the sticky flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cont_prev_r  <= 1'b0;
      contention_r <= 1'b0;
    end else begin
      cont_prev_r  <= cont_flag_s;
      contention_r <= contention_r | (cont_flag_s & cont_prev_r);
    end
  end

  assign contention = contention_r;
`endif

endmodule
